// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry/timing for the external SRAM sequencer.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_RD_WAIT  = 2;
  localparam int DEF_WR_PULSE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SETUP,
    ST_RD_WAIT,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;

  // Larger of two phase lengths; sizes the shared wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times the read-wait and write-strobe phases.
module sram_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Sequencer between the processor memory port and an asynchronous SRAM.
// Every SRAM-side pin comes straight from a flop; strobe levels are decoded
// from the next state so they change exactly on the state boundaries.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_WAIT  = DEF_RD_WAIT,
  parameter int WR_PULSE = DEF_WR_PULSE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic [ADDR_W-1:0] sram_adr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  if (RD_WAIT < 1 || WR_PULSE < 1) begin : g_param_check
    $error("sram_bus_ctrl: RD_WAIT and WR_PULSE must both be at least 1");
  end

  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_PULSE) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                wdone_q, wdone_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_en;
  logic                cnt_tc;

  sram_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  // Next-state and next-output logic; pins are decoded from state_d so the
  // registered strobes line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    adr_d    = adr_q;
    dq_out_d = dq_out_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = RD_LOAD;
    cnt_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d    = addr;
          dq_out_d = wdata;
          state_d  = we_req ? ST_WR_SETUP : ST_RD_SETUP;
        end
      end
      ST_RD_SETUP: begin
        cnt_load = 1'b1;
        cnt_val  = RD_LOAD;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_tc) begin
          rdata_d  = sram_dq;
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        cnt_load = 1'b1;
        cnt_val  = WR_LOAD;
        state_d  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_tc) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        wdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Data is only driven in write states, which are never adjacent to
    // RD_WAIT, so oe_n is always high for a full cycle before dq is driven.
    ready_d = (state_d == ST_IDLE);
    ce_n_d  = (state_d == ST_IDLE);
    oe_n_d  = (state_d != ST_RD_WAIT);
    we_n_d  = (state_d != ST_WR_PULSE);
    dq_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
              (state_d == ST_WR_HOLD);
  end

  // State and registered outputs; reset parks all strobes high and releases dq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      rdata_q  <= '0;
      adr_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      rdata_q  <= rdata_d;
      adr_q    <= adr_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign sram_dq   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};

  assign ready     = ready_q;
  assign rvalid    = rvalid_q;
  assign wdone     = wdone_q;
  assign rdata     = rdata_q;
  assign sram_adr  = adr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl with a behavioural asynchronous SRAM.
// A pull-up on the data bus makes a released bus read back as all ones.
module tb_sram_bus_ctrl;

  localparam int RW = 2;
  localparam int WP = 2;
  localparam logic [15:0] BUS_IDLE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we_req = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        ready, rvalid, wdone;
  logic [15:0] rdata;
  logic [7:0]  sram_adr;
  logic        ce, oe, we;
  wire  [15:0] sram_dq;

  sram_bus_ctrl #(
    .ADDR_W(8), .DATA_W(16), .RD_WAIT(RW), .WR_PULSE(WP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we_req(we_req), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid), .wdone(wdone),
    .sram_adr(sram_adr), .sram_ce_n(ce), .sram_oe_n(oe), .sram_we_n(we),
    .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: drives the bus while selected and output-enabled.
  logic [15:0] mem [256];
  pullup (sram_dq);
  assign sram_dq = (!ce && !oe && we) ? mem[sram_adr] : 16'bz;
  always @(posedge clk) if (reset_n && !ce && !we) mem[sram_adr] <= sram_dq;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req_v, cyc);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] rd_hold_exp = '0;
  logic        oe_prev = 1'b1;

  // Monitor: pops one expectation per completion pulse and watches the bus.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rvalid || wdone) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual rvalid=%0b wdone=%0b required no pulse (cyc %0d)",
                   rvalid, wdone, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind_wdone", 32'(wdone), 32'(mon_e.is_wr));
          chk("pulse_kind_rvalid", 32'(rvalid), 32'(!mon_e.is_wr));
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.due));
          if (!mon_e.is_wr) begin
            chk("rdata", 32'(rdata), 32'(mon_e.data));
            rd_hold_exp = mon_e.data;
          end
        end
      end else begin
        chk("rdata_held", 32'(rdata), 32'(rd_hold_exp));
      end
      if (!oe) begin
        chk("oe_we_exclusive", 32'(we), 32'd1);
        chk("dq_no_contention", 32'(sram_dq), 32'(mem[sram_adr]));
      end else if (sram_dq !== BUS_IDLE) begin
        chk("dq_drive_after_oe_high", 32'(oe_prev), 32'd1);
      end
      oe_prev = oe;
    end else begin
      oe_prev = 1'b1;
    end
  end

  // Present a request and wait (bounded) until the DUT is ready to take it.
  // Returns at the falling edge just before the accepting rising edge.
  task automatic issue(input bit w, input logic [7:0] a, input logic [15:0] d,
                       output int nacc);
    int n;
    n = 0;
    @(negedge clk);
    req = 1'b1; we_req = w; addr = a; wdata = d;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual ready=0 required ready=1 within 50 cycles");
      req = 1'b0;
      nacc = -1;
    end else begin
      nacc = cyc + 1;
      sb.push_back('{is_wr: w, data: d, due: (w ? nacc + 2 + WP : nacc + 1 + RW)});
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int n0, n1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wdone", 32'(wdone), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_adr", 32'(sram_adr), 32'd0);
    chk("rst_ce_n", 32'(ce), 32'd1);
    chk("rst_oe_n", 32'(oe), 32'd1);
    chk("rst_we_n", 32'(we), 32'd1);
    chk("rst_dq_released", 32'(sram_dq), 32'(BUS_IDLE));
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Write 0x002D to address 32 and check the strobe windows cycle by cycle
    issue(1'b1, 8'd32, 16'h002D, n0);
    for (int off = 1; off <= 5; off++) begin
      @(negedge clk);
      if (off == 1) req = 1'b0;
      $display("write strobe cycle N+%0d: ce_n=%0b we_n=%0b oe_n=%0b dq=%h", off, ce, we, oe, sram_dq);
      chk("wr_we_n", 32'(we), (off >= 2 && off <= 1 + WP) ? 32'd0 : 32'd1);
      chk("wr_ce_n", 32'(ce), (off <= 2 + WP) ? 32'd0 : 32'd1);
      chk("wr_oe_n", 32'(oe), 32'd1);
      chk("wr_dq", 32'(sram_dq), (off <= 2 + WP) ? 32'h002D : 32'(BUS_IDLE));
      if (off <= 2 + WP) chk("wr_adr", 32'(sram_adr), 32'd32);
    end
    chk("mem32_written", 32'(mem[32]), 32'h002D);

    // Read back address 32; oe_n window, then rvalid via the scoreboard
    issue(1'b0, 8'd32, 16'h002D, n0);
    for (int off = 1; off <= 5; off++) begin
      @(negedge clk);
      if (off == 1) req = 1'b0;
      $display("read strobe cycle N+%0d: ce_n=%0b oe_n=%0b rvalid=%0b rdata=%h", off, ce, oe, rvalid, rdata);
      chk("rd_oe_n", 32'(oe), (off >= 2 && off <= 1 + RW) ? 32'd0 : 32'd1);
      chk("rd_ce_n", 32'(ce), (off <= 1 + RW) ? 32'd0 : 32'd1);
      chk("rd_we_n", 32'(we), 32'd1);
    end
    idle_cycles(3);

    // Read immediately followed by write with req held high
    issue(1'b0, 8'd32, 16'h002D, n0);
    issue(1'b1, 8'd5, 16'h8123, n1);
    $display("back-to-back: read accepted edge %0d, write accepted edge %0d", n0, n1);
    chk("b2b_accept_edge", 32'(n1), 32'(n0 + 2 + RW));
    @(negedge clk);
    req = 1'b0;
    idle_cycles(6);
    chk("mem5_written", 32'(mem[5]), 32'h8123);

    // Read back with bit 15 set
    issue(1'b0, 8'd5, 16'h8123, n0);
    @(negedge clk);
    req = 1'b0;
    idle_cycles(5);

    // Request pulsed during RD_WAIT must be ignored
    issue(1'b0, 8'd32, 16'h002D, n0);
    @(negedge clk);                     // cycle N+1
    req = 1'b0;
    @(negedge clk);                     // cycle N+2, first wait cycle
    chk("ign_in_wait_oe_n", 32'(oe), 32'd0);
    req = 1'b1; we_req = 1'b1; addr = 8'd9; wdata = 16'h1111;
    chk("ign_ready_low_a", 32'(ready), 32'd0);
    @(negedge clk);                     // cycle N+3
    chk("ign_ready_low_b", 32'(ready), 32'd0);
    req = 1'b0;
    idle_cycles(3);
    $display("ignored request: ready=%0b ce_n=%0b mem[9]=%h", ready, ce, mem[9]);
    chk("ign_ready_back", 32'(ready), 32'd1);
    chk("ign_no_new_access", 32'(ce), 32'd1);
    chk("ign_mem9_untouched", 32'(mem[9]), 32'h0909);

    // Asynchronous reset during the write strobe
    issue(1'b1, 8'd7, 16'h0BEE, n0);
    @(negedge clk);                     // cycle N+1
    req = 1'b0;
    @(negedge clk);                     // cycle N+2, strobe low
    chk("arst_we_low_before", 32'(we), 32'd0);
    #2;
    reset_n = 1'b0;
    sb.delete();
    rd_hold_exp = '0;
    #1;
    $display("async reset mid-write: we_n=%0b ce_n=%0b dq=%h ready=%0b", we, ce, sram_dq, ready);
    chk("arst_we_n", 32'(we), 32'd1);
    chk("arst_ce_n", 32'(ce), 32'd1);
    chk("arst_dq_released", 32'(sram_dq), 32'(BUS_IDLE));
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    idle_cycles(6);                     // monitor flags any stray wdone

    // Normal read after the interrupted write
    issue(1'b0, 8'd32, 16'h002D, n0);
    @(negedge clk);
    req = 1'b0;
    idle_cycles(6);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Single-clock sequencer between the processor's memory port and the external asynchronous SRAM. It replaces the PCB glue logic (ce/oe/we derived directly from MemWrite) with explicit setup, strobe and hold phases. It also owns the bidirectional data bus, so the processor never fights the SRAM on a read/write turnaround. Processor side is a req/ready handshake with one-cycle completion pulses.

## Interface
- ADDR_W, 8, address width (256-word SRAM)
- DATA_W, 16, data bus width; processor uses bits 14:0, bit 15 is passed through untouched
- RD_WAIT, 2, cycles oe_n held low before data is sampled; legal range ≥1
- WR_PULSE, 2, cycles we_n held low; legal range ≥1

- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  access request, qualified by ready
- we_req  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address, sampled with req
- wdata  in  DATA_W  write data, sampled with req
- ready  out  1  high only in IDLE; request accepted on edge where req & ready
- rdata  out  DATA_W  last completed read data; held until next read completes
- rvalid  out  1  one-cycle pulse, rdata valid
- wdone  out  1  one-cycle pulse, write finished
- sram_adr  out  ADDR_W  SRAM address
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_dq  inout  DATA_W  SRAM data bus; high-Z unless this block drives it

## Operation
- States: IDLE, RD_SETUP, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: ready=1, ce_n/oe_n/we_n=1, dq high-Z. On req: latch addr/wdata/we_req, go RD_SETUP or WR_SETUP.
- RD_SETUP (1 cycle): ce_n=0, adr driven, oe_n=1 → RD_WAIT.
- RD_WAIT (RD_WAIT cycles, down-counter): ce_n=0, oe_n=0; sram_dq captured into rdata at the edge ending the last wait cycle → IDLE, rvalid=1 in that IDLE cycle.
- WR_SETUP (1 cycle): ce_n=0, adr and dq driven, we_n=1 → WR_PULSE.
- WR_PULSE (WR_PULSE cycles): we_n=0, dq driven → WR_HOLD.
- WR_HOLD (1 cycle): we_n=1, adr and dq still driven → IDLE, wdone=1 in that IDLE cycle.
- Turnaround rule: dq is driven only after oe_n has been high for ≥1 full cycle; oe_n and dq-drive are never active in the same cycle.
- req while ready=0 is ignored (not queued); the processor holds req until accepted.
- Back-to-back: a new req is accepted in the same IDLE cycle that carries rvalid/wdone.
- Reset asserted mid-operation: all strobes high, dq released, state IDLE immediately (asynchronous). An interrupted write leaves SRAM contents at that address undefined; no wdone is issued.
- Parameters <1 are rejected by an elaboration-time assertion.

## Timing
- Reset values: ready=1, rvalid=0, wdone=0, rdata=0, sram_adr=0, sram_ce_n/oe_n/we_n=1, sram_dq=Z.
- Request accepted at edge N. Read: rvalid high in cycle N+2+RD_WAIT (N+4 at default).
- Write: wdone high in cycle N+3+WR_PULSE (N+5 at default).
- Throughput: one read per 2+RD_WAIT cycles; one write per 3+WR_PULSE cycles.
- All SRAM-side outputs are registered; no combinational path from req to SRAM pins.

## Structure
- Package sram_ctrl_pkg: state enum typedef, default ADDR_W/DATA_W/RD_WAIT/WR_PULSE constants.
- One sub-module: sram_wait_cnt, a loadable down-counter shared by RD_WAIT and WR_PULSE phases, terminal-count output.
- Tristate: single continuous assign on sram_dq gated by a registered drive-enable.

## Test plan
- Reset: hold reset_n=0, toggle clk → all outputs at reset values, dq=Z; release → ready=1.
- Write 16'h002D to addr 8'd32 at edge N → we_n low exactly cycles N+2..N+3, wdone pulse at N+5; SRAM model holds 16'h002D.
- Read addr 8'd32 → oe_n low cycles N+2..N+3, rvalid at N+4, rdata=16'h002D, held after pulse.
- Read immediately followed by write (req held high) → accepted in rvalid cycle; checker confirms dq never driven while oe_n=0.
- req pulsed during RD_WAIT → ignored; no extra rvalid; ready stays low until IDLE.
- reset_n low during WR_PULSE → we_n=1 and dq=Z in same timestep (async), no wdone; subsequent read completes normally.
